// File: rtl/pong_score_serve_ctrl.sv
// Pong score keeper and serve sequencer: detects goals from the ball position,
// counts points, runs the serve countdown and freezes the ball between rallies.
module pong_score_serve_ctrl #(
  parameter int GOAL_MARGIN = 4,
  parameter int SERVE_DELAY = 60,
  parameter int WIN_SCORE   = 7
) (
  input  logic       game_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] x_ball,
  input  logic [4:0] width_ball,
  input  logic       x_ball_dir,
  input  logic [9:0] x_lwall,
  input  logic [9:0] x_rwall,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       ball_hold,
  output logic       serve_dir,
  output logic       serve_pulse,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    PLAY       = 3'd2,
    POINT      = 3'd3,
    GAME_OVER  = 3'd4
  } state_t;

  localparam logic [10:0] MARGIN     = 11'(GOAL_MARGIN);
  localparam logic [9:0]  DELAY_LOAD = 10'(SERVE_DELAY - 1);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

  // state is kept as a named register so checkers can bind to it directly
  state_t     state, state_nxt;
  logic [9:0] cnt, cnt_nxt;
  logic [3:0] score_l_nxt, score_r_nxt;
  logic [3:0] score_l_inc, score_r_inc;
  logic       serve_dir_nxt, winner_nxt;
  logic       point_right, point_right_nxt;
  logic       ball_hold_nxt, serve_pulse_nxt, game_over_nxt;

  logic [10:0] right_edge, left_limit, right_limit;
  logic        goal_l, goal_r;

  // 11-bit sums so a ball near x=1023 cannot wrap past the goal line
  assign right_edge  = {1'b0, x_ball} + {6'd0, width_ball};
  assign left_limit  = {1'b0, x_lwall} + MARGIN;
  assign right_limit = ({1'b0, x_rwall} >= MARGIN) ? ({1'b0, x_rwall} - MARGIN) : 11'd0;

  // The serve tick still carries the stale pre-serve position, so it never scores
  assign goal_l = (state == PLAY) && !serve_pulse && !x_ball_dir &&
                  ({1'b0, x_ball} <= left_limit);
  assign goal_r = (state == PLAY) && !serve_pulse && x_ball_dir &&
                  (right_edge >= right_limit);

  assign score_l_inc = (score_l == WIN) ? score_l : score_l + 4'd1;
  assign score_r_inc = (score_r == WIN) ? score_r : score_r + 4'd1;

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    score_l_nxt     = score_l;
    score_r_nxt     = score_r;
    serve_dir_nxt   = serve_dir;
    winner_nxt      = winner;
    point_right_nxt = point_right;

    case (state)
      IDLE: begin
        if (start) begin
          score_l_nxt = 4'd0;
          score_r_nxt = 4'd0;
          cnt_nxt     = DELAY_LOAD;
          state_nxt   = SERVE_WAIT;
        end
      end
      SERVE_WAIT: begin
        if (cnt == 10'd0) begin
          state_nxt = PLAY;
        end else begin
          cnt_nxt = cnt - 10'd1;
        end
      end
      PLAY: begin
        if (goal_l) begin
          point_right_nxt = 1'b1;
          state_nxt       = POINT;
        end else if (goal_r) begin
          point_right_nxt = 1'b0;
          state_nxt       = POINT;
        end
      end
      POINT: begin
        // The next serve heads toward the player who just conceded
        if (point_right) begin
          score_r_nxt   = score_r_inc;
          serve_dir_nxt = 1'b0;
        end else begin
          score_l_nxt   = score_l_inc;
          serve_dir_nxt = 1'b1;
        end
        if ((point_right ? score_r_inc : score_l_inc) == WIN) begin
          winner_nxt = point_right;
          state_nxt  = GAME_OVER;
        end else begin
          cnt_nxt   = DELAY_LOAD;
          state_nxt = SERVE_WAIT;
        end
      end
      GAME_OVER: begin
        if (start) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    ball_hold_nxt   = (state_nxt != PLAY);
    serve_pulse_nxt = (state == SERVE_WAIT) && (state_nxt == PLAY);
    game_over_nxt   = (state_nxt == GAME_OVER);
  end

  always_ff @(posedge game_clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 10'd0;
      score_l     <= 4'd0;
      score_r     <= 4'd0;
      serve_dir   <= 1'b1;
      winner      <= 1'b0;
      point_right <= 1'b0;
      ball_hold   <= 1'b1;
      serve_pulse <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      score_l     <= score_l_nxt;
      score_r     <= score_r_nxt;
      serve_dir   <= serve_dir_nxt;
      winner      <= winner_nxt;
      point_right <= point_right_nxt;
      ball_hold   <= ball_hold_nxt;
      serve_pulse <= serve_pulse_nxt;
      game_over   <= game_over_nxt;
    end
  end

endmodule

// File: tb/tb_pong_score_serve_ctrl.sv
// Bench for pong_score_serve_ctrl: directed rallies, randomized games and
// asynchronous reset, checked against a rule-level game model.
module tb_pong_score_serve_ctrl;

  localparam int SD  = 60;
  localparam int WIN = 7;
  localparam int GM  = 4;

  logic       game_clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [9:0] x_ball = 10'd320;
  logic [4:0] width_ball = 5'd8;
  logic       x_ball_dir = 1'b0;
  logic [9:0] x_lwall = 10'd8;
  logic [9:0] x_rwall = 10'd632;
  logic [3:0] score_l, score_r;
  logic       ball_hold, serve_dir, serve_pulse, game_over, winner;

  int n_checks = 0;
  int n_pass   = 0;

  // game model: scores, next serve direction, end-of-game
  int m_l = 0, m_r = 0, m_dir = 1, m_over = 0, m_win = 0;
  logic [8:0] exp_q[$];

  always #5 game_clk = ~game_clk;

  pong_score_serve_ctrl #(
    .GOAL_MARGIN(GM),
    .SERVE_DELAY(SD),
    .WIN_SCORE(WIN)
  ) dut (
    .game_clk(game_clk),
    .reset(reset),
    .start(start),
    .x_ball(x_ball),
    .width_ball(width_ball),
    .x_ball_dir(x_ball_dir),
    .x_lwall(x_lwall),
    .x_rwall(x_rwall),
    .score_l(score_l),
    .score_r(score_r),
    .ball_hold(ball_hold),
    .serve_dir(serve_dir),
    .serve_pulse(serve_pulse),
    .game_over(game_over),
    .winner(winner)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // 0 = no goal, 1 = ball through the left line, 2 = through the right line
  function automatic int model_goal(int xb, int w, int dir, int lw, int rw);
    int lim;
    lim = (rw >= GM) ? rw - GM : 0;
    if (dir == 0 && xb <= lw + GM) return 1;
    if (dir == 1 && xb + w >= lim) return 2;
    return 0;
  endfunction

  task automatic drive(input int xb, input int w, input int dir, input int lw, input int rw);
    x_ball = 10'(xb); width_ball = 5'(w); x_ball_dir = dir[0];
    x_lwall = 10'(lw); x_rwall = 10'(rw);
  endtask

  task automatic drive_noise();
    drive($urandom_range(0, 1023), $urandom_range(0, 31), $urandom_range(0, 1),
          $urandom_range(0, 1023), $urandom_range(0, 1023));
    start = 1'($urandom_range(0, 1));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hold"}, ball_hold, 1);
    check({tag, "_score_l"}, score_l, 0);
    check({tag, "_score_r"}, score_r, 0);
    check({tag, "_serve_dir"}, serve_dir, 1);
    check({tag, "_game_over"}, game_over, 0);
    check({tag, "_serve_pulse"}, serve_pulse, 0);
  endtask

  // Called on the negedge right after the event that starts a hold; counts
  // held ticks until release, then checks that a stale goal on the serve tick is ignored.
  task automatic wait_release(input string tag, input int exp_len);
    int cnt = 0;
    bit done = 1'b0;
    while (!done) begin
      @(negedge game_clk);
      if (!ball_hold) done = 1'b1;
      else begin
        cnt++;
        if (cnt > exp_len + 20) done = 1'b1;
        else drive_noise();
      end
    end
    start = 1'b0;
    check({tag, "_hold_len"}, cnt, exp_len);
    check({tag, "_serve_pulse"}, serve_pulse, 1);
    drive(3, 8, 0, 8, 632);
    @(negedge game_clk);
    check({tag, "_stale_goal"}, ball_hold, 0);
    check({tag, "_pulse_once"}, serve_pulse, 0);
    drive(320, 8, 1, 8, 632);
  endtask

  task automatic start_game(input string tag);
    m_l = 0; m_r = 0; m_over = 0;
    exp_q.delete();
    start = 1'b1;
    wait_release(tag, SD);
    check({tag, "_new_l"}, score_l, 0);
    check({tag, "_new_r"}, score_r, 0);
  endtask

  // One PLAY tick with the given ball state; resolves the point if it scores.
  task automatic step_play(input string tag, input int xb, input int w, input int dir,
                           input int lw, input int rw);
    int g;
    logic [8:0] exp;
    drive(xb, w, dir, lw, rw);
    start = 1'($urandom_range(0, 1));
    g = model_goal(xb, w, dir, lw, rw);
    @(negedge game_clk);
    if (g == 0) begin
      check({tag, "_play_hold"}, ball_hold, 0);
      return;
    end
    check({tag, "_point_hold"}, ball_hold, 1);
    if (g == 1) begin m_r++; m_dir = 0; end
    else begin m_l++; m_dir = 1; end
    exp_q.push_back({m_dir[0], m_l[3:0], m_r[3:0]});
    drive_noise();
    if (m_l == WIN || m_r == WIN) begin
      m_over = 1;
      m_win = (m_r == WIN) ? 1 : 0;
      @(negedge game_clk);
      start = 1'b0;
      check({tag, "_game_over"}, game_over, 1);
      check({tag, "_winner"}, winner, m_win);
      check({tag, "_go_hold"}, ball_hold, 1);
    end else begin
      wait_release(tag, SD);
    end
    exp = exp_q.pop_front();
    check({tag, "_sb"}, {serve_dir, score_l, score_r}, exp);
  endtask

  task automatic rand_play(input string tag);
    int lw, rw, w, dir, xb, lim, mode;
    lw = $urandom_range(0, 40);
    rw = $urandom_range(560, 1023);
    w = $urandom_range(0, 31);
    dir = $urandom_range(0, 1);
    mode = $urandom_range(0, 9);
    if (mode == 0) lw = $urandom_range(1015, 1023);
    if (mode == 1) rw = $urandom_range(0, 5);
    lim = (rw >= GM) ? rw - GM : 0;
    if (mode >= 6) xb = $urandom_range(100, 500);
    else if (mode == 2) xb = 1023 - $urandom_range(0, 5);
    else if (dir == 0) xb = lw + GM + $urandom_range(0, 4) - 2;
    else xb = lim - w + $urandom_range(0, 4) - 2;
    if (xb < 0) xb = 0;
    if (xb > 1023) xb = 1023;
    step_play(tag, xb, w, dir, lw, rw);
  endtask

  task automatic play_game(input string tag);
    int it = 0;
    while (!m_over && it < 300) begin
      rand_play(tag);
      it++;
    end
    check({tag, "_finished"}, m_over, 1);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge game_clk);
    check_reset_vals("rst");
    reset = 1'b1;
    repeat (10) @(negedge game_clk);
    check_reset_vals("idle");

    start_game("g1");
    step_play("l_dir1", 12, 8, 1, 8, 632);
    step_play("l_goal", 12, 8, 0, 8, 632);
    step_play("r_619", 619, 8, 1, 8, 632);
    step_play("r_620", 620, 8, 1, 8, 632);
    for (int i = 0; i < 6; i++) step_play("r_run", 620, 8, 1, 8, 632);
    check("g1_left_won", m_over, 1);

    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive($urandom_range(0, 20), 8, $urandom_range(0, 1), 8, 632);
      @(negedge game_clk);
      check("frozen_l", score_l, 7);
      check("frozen_r", score_r, 1);
      check("frozen_go", game_over, 1);
    end
    start = 1'b1;
    @(negedge game_clk);
    start = 1'b0;
    check("restart_go_drop", game_over, 0);
    check("restart_idle_hold", ball_hold, 1);
    repeat (3) @(negedge game_clk);
    check("idle_waits", ball_hold, 1);

    start_game("g2");
    play_game("g2");
    // start held through GAME_OVER -> IDLE restarts straight away
    start = 1'b1;
    @(negedge game_clk);
    check("hold_start_go_drop", game_over, 0);
    start_game("g3");
    play_game("g3");
    start = 1'b1;
    @(negedge game_clk);
    start_game("g4");
    for (int i = 0; i < 3; i++) step_play("d_r", 620, 8, 1, 8, 632);
    for (int i = 0; i < 5; i++) step_play("d_l", 12, 8, 0, 8, 632);
    step_play("d_mid", 320, 8, 1, 8, 632);
    #2 reset = 1'b0;
    #1 check_reset_vals("rst_play");
    @(negedge game_clk);
    reset = 1'b1;
    @(negedge game_clk);
    start = 1'b1;
    @(negedge game_clk);
    start = 1'b0;
    repeat (20) @(negedge game_clk);
    check("sw_hold", ball_hold, 1);
    #2 reset = 1'b0;
    #1 check_reset_vals("rst_sw");
    @(negedge game_clk);
    reset = 1'b1;
    repeat (SD + 5) @(negedge game_clk);
    check("post_rst_idle_hold", ball_hold, 1);
    check("post_rst_idle_pulse", serve_pulse, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
